// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 10-bit UART transmit shifter between
// NUM_REQ byte producers, with baud-rate bit_tick generation.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   req_valid    per-requester byte request
//   req_data     requester i byte on bits [8i+7:8i]
//   req_ready    one-cycle accept pulse to the granted requester
//   tx_data      byte presented to the shifter
//   byte_ready   one-cycle load strobe to the shifter
//   bit_tick     one-cycle shift strobe, one per bit-time
//   busy         frame or inter-frame gap in progress
//   grant_id     index of the current/last granted requester
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_BITS     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       byte_ready,
  output logic                       bit_tick,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int FRAME = 10 + GAP_BITS;
  localparam int BW    = $clog2(FRAME + 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]      ptr, ptr_n;
  logic [CW-1:0]      baud, baud_n;
  logic [BW-1:0]      bcnt, bcnt_n;
  logic [NUM_REQ-1:0] rdy_n;
  logic [7:0]         txd_n;
  logic               br_n;
  logic               tick_n;
  logic               busy_n;
  logic [IW-1:0]      gid_n;

  logic [7:0]    bytes [NUM_REQ];
  logic          found;
  logic [IW-1:0] gnt;
  logic          arb;
  logic          last;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bytes[i] = req_data[8*i +: 8];
    end
  end

  // Search from ptr+1 upward with wrap; first valid index wins.
  always_comb begin
    int j;
    found = 1'b0;
    gnt   = '0;
    j     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!found && req_valid[IW'(j)]) begin
        found = 1'b1;
        gnt   = IW'(j);
      end
    end
  end

  // The final tick of a frame (plus gap) doubles as the
  // arbitration slot, giving a (FRAME*C + 1)-cycle period.
  assign last = (state != IDLE) && bit_tick &&
                (bcnt == BW'(FRAME));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    baud_n  = baud;
    bcnt_n  = bcnt;
    rdy_n   = '0;
    txd_n   = tx_data;
    br_n    = 1'b0;
    tick_n  = 1'b0;
    busy_n  = busy;
    gid_n   = grant_id;
    arb     = 1'b0;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        arb    = found;
      end
      SEND, GAP: begin
        if (baud == CW'(CLKS_PER_BIT - 1)) begin
          baud_n = '0;
          tick_n = 1'b1;
          bcnt_n = bcnt + 1'b1;
        end else begin
          baud_n = baud + 1'b1;
        end
        if (state == SEND && bit_tick &&
            bcnt == BW'(10)) begin
          state_n = GAP;
        end
        if (last) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          baud_n  = '0;
          bcnt_n  = '0;
          arb     = found;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase

    if (arb) begin
      state_n    = SEND;
      ptr_n      = gnt;
      baud_n     = '0;
      bcnt_n     = '0;
      rdy_n[gnt] = 1'b1;
      txd_n      = bytes[gnt];
      br_n       = 1'b1;
      busy_n     = 1'b1;
      gid_n      = gnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= IW'(NUM_REQ - 1);
      baud       <= '0;
      bcnt       <= '0;
      req_ready  <= '0;
      tx_data    <= 8'h00;
      byte_ready <= 1'b0;
      bit_tick   <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      baud       <= baud_n;
      bcnt       <= bcnt_n;
      req_ready  <= rdy_n;
      tx_data    <= txd_n;
      byte_ready <= br_n;
      bit_tick   <= tick_n;
      busy       <= busy_n;
      grant_id   <= gid_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: default instance (C=16, G=1)
// plus a C=4, G=0 instance for the no-gap back-to-back case.
module tb_uart_tx_sched;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic [7:0]   tx_data;
  logic         byte_ready, bit_tick, busy;
  logic [1:0]   grant_id;

  logic [N-1:0]   v0 = '0;
  logic [8*N-1:0] d0 = '0;
  logic [N-1:0]   rr0;
  logic [7:0]     txd0;
  logic           br0, tk0, bz0;
  logic [1:0]     gid0;

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(16), .GAP_BITS(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data),
    .byte_ready(byte_ready), .bit_tick(bit_tick),
    .busy(busy), .grant_id(grant_id)
  );

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(4), .GAP_BITS(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_data(d0),
    .req_ready(rr0), .tx_data(txd0),
    .byte_ready(br0), .bit_tick(tk0),
    .busy(bz0), .grant_id(gid0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;
  int viol = 0;
  int br_cnt = 0;
  int rr1_cnt = 0;
  int rr3_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (req_ready != '0 && !byte_ready) viol++;
      if ($countones(req_ready) > 1) viol++;
      if (bit_tick && !busy) viol++;
      if (rr0 != '0 && !br0) viol++;
      if ($countones(rr0) > 1) viol++;
      if (tk0 && !bz0) viol++;
      if (byte_ready) br_cnt++;
      if (req_ready[1]) rr1_cnt++;
      if (req_ready[3]) rr3_cnt++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_br(input int budget, output int at,
                         output int lows);
    at = -1;
    lows = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (byte_ready) begin
        at = cyc;
        return;
      end
      if (!busy) lows++;
    end
    chk("br_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy && !bz0) begin
        at = cyc;
        return;
      end
    end
    chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int t0, t1, te, lows, nt, sp, last, extra, nb, prev, tks, s0, s1;
    logic [9:0] sh;
    logic [9:0] seq;

    #2 reset = 1'b1;
    repeat (3) step();
    chk("rst_out", {16'h0, req_ready, tx_data, byte_ready,
                    bit_tick, busy, grant_id}, 0);
    chk("rst_busy0", 32'(bz0), 0);
    reset = 1'b0;
    step();

    // single request on port 2
    req_data[23:16] = 8'hA5;
    req_valid = 4'b0100;
    step();
    chk("t1_br", 32'(byte_ready), 1);
    chk("t1_rdy", 32'(req_ready), 32'h4);
    chk("t1_txd", 32'(tx_data), 32'hA5);
    chk("t1_gid", 32'(grant_id), 2);
    chk("t1_busy", 32'(busy), 1);
    t0 = cyc;
    req_valid = '0;
    nt = 0; sp = 0; last = t0; extra = 0;
    sh = {1'b1, tx_data, 1'b0};
    seq = '0;
    for (int i = 0; i < 400 && busy; i++) begin
      step();
      if (bit_tick) begin
        if (nt < 10) seq[nt] = sh[0];
        sh = {1'b1, sh[9:1]};
        nt++;
        if (cyc - last != 16) sp++;
        last = cyc;
      end
      if (byte_ready) extra++;
    end
    chk("t1_ticks", nt, 11);
    chk("t1_spacing", sp, 0);
    chk("t1_line", 32'(seq), 32'h34A);
    chk("t1_extra_br", extra, 0);
    chk("t1_busy_len", cyc - t0, 177);
    chk("t1_txd_hold", 32'(tx_data), 32'hA5);
    chk("t1_gid_hold", 32'(grant_id), 2);

    // all four continuously valid, starting from reset pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
    req_valid = 4'hF;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_br(200, t1, lows);
      if (g > 0) begin
        chk("rr_period", t1 - prev, 177);
        chk("rr_busy_drop", lows, 0);
      end
      chk("rr_gid", 32'(grant_id), g % 4);
      chk("rr_rdy", 32'(req_ready), 32'(1) << (g % 4));
      chk("rr_txd", 32'(tx_data), 32'h10 + (g % 4));
      prev = t1;
    end
    req_valid = '0;
    wait_idle(300, te);

    // mid-frame request on another port (pointer now 0)
    req_data[15:8] = 8'h31;
    req_valid = 4'b0010;
    wait_br(10, t0, lows);
    chk("mid_gid1", 32'(grant_id), 1);
    req_valid = '0;
    repeat (49) step();
    s1 = rr1_cnt;
    req_data[31:24] = 8'h33;
    req_valid[3] = 1'b1;
    wait_br(300, t1, lows);
    chk("mid_wait", t1 - t0, 177);
    chk("mid_gid3", 32'(grant_id), 3);
    chk("mid_rdy", 32'(req_ready), 32'h8);
    chk("mid_txd", 32'(tx_data), 32'h33);
    chk("mid_no_rep", rr1_cnt - s1, 0);
    req_valid = '0;
    wait_idle(300, te);

    // withdrawn request on port 3
    req_data[7:0] = 8'h40;
    req_valid = 4'b0001;
    wait_br(10, t0, lows);
    chk("wd_gid0", 32'(grant_id), 0);
    req_valid = '0;
    repeat (39) step();
    s0 = br_cnt;
    s1 = rr3_cnt;
    req_data[31:24] = 8'h77;
    req_valid[3] = 1'b1;
    repeat (60) step();
    req_valid[3] = 1'b0;
    wait_idle(200, te);
    chk("wd_busy_len", te - t0, 177);
    chk("wd_no_br", br_cnt - s0, 0);
    chk("wd_no_rdy3", rr3_cnt - s1, 0);

    // no-gap instance, back-to-back on port 1
    d0[15:8] = 8'h5A;
    v0 = 4'b0010;
    nb = 0; prev = 0; tks = 0; lows = 0;
    for (int i = 0; i < 300 && nb < 4; i++) begin
      step();
      if (nb > 0 && !bz0) lows++;
      if (tk0) tks++;
      if (br0) begin
        if (nb > 0) begin
          chk("g0_period", cyc - prev, 41);
          chk("g0_ticks", tks, 10);
        end
        chk("g0_gid", 32'(gid0), 1);
        chk("g0_rdy", 32'(rr0), 32'h2);
        chk("g0_txd", 32'(txd0), 32'h5A);
        prev = cyc;
        tks = 0;
        nb++;
      end
    end
    chk("g0_frames", nb, 4);
    chk("g0_busy_drop", lows, 0);
    v0 = '0;
    wait_idle(100, te);

    // async reset at tick 5 of a frame
    req_data[23:16] = 8'h62;
    req_valid = 4'b0100;
    wait_br(10, t0, lows);
    chk("ar_gid2", 32'(grant_id), 2);
    req_valid = '0;
    nt = 0;
    for (int i = 0; i < 200 && nt < 5; i++) begin
      step();
      if (bit_tick) nt++;
    end
    chk("ar_tick5", nt, 5);
    reset = 1'b1;
    req_data[15:8] = 8'h11;
    req_data[31:24] = 8'h33;
    req_valid = 4'b1010;
    #1;
    chk("ar_out", {16'h0, req_ready, tx_data, byte_ready,
                   bit_tick, busy, grant_id}, 0);
    nt = 0; extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bit_tick) nt++;
      if (byte_ready || req_ready != '0) extra++;
    end
    chk("ar_no_tick", nt, 0);
    chk("ar_no_pulse", extra, 0);
    reset = 1'b0;
    step();
    chk("ar_br", 32'(byte_ready), 1);
    chk("ar_gid", 32'(grant_id), 1);
    chk("ar_rdy", 32'(req_ready), 32'h2);
    chk("ar_txd", 32'(tx_data), 32'h11);
    req_valid = '0;
    wait_idle(300, te);

    chk("protocol_viol", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one 10-bit UART transmit shifter (start + 8 data + stop, LSB first) between NUM_REQ byte producers.
- Grants one requester per frame and loads its byte into the shifter with a one-cycle byte_ready pulse.
- Generates the bit_tick strobe that paces the shifter at the baud rate, and blocks new grants until the frame and the inter-frame gap have completed.
- Sits between the requester logic and the shifter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CLKS_PER_BIT, 16, clk cycles per UART bit-time (>=2)
- GAP_BITS, 1, extra idle bit-times after each stop bit (0..15)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte request
- req_data  in  8*NUM_REQ  requester i byte on bits [8i+7:8i]
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
- tx_data  out  8  byte presented to the shifter
- byte_ready  out  1  one-cycle load strobe to the shifter
- bit_tick  out  1  one-cycle shift strobe, one per bit-time
- busy  out  1  frame or gap in progress
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester

Behaviour:
- Clock and reset: single clk domain. Reset is asynchronous, active-high. All outputs are registered.
- Reset values: req_ready=0, tx_data=8'h00, byte_ready=0, bit_tick=0, busy=0, grant_id=0. Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: no frame in progress.
  - SEND: 10 bit-times of the frame.
  - GAP: GAP_BITS bit-times; skipped when GAP_BITS=0.
- Arbitration in IDLE:
  - Trigger: any req_valid is sampled high at edge k.
  - Search order: starting at pointer+1 and wrapping; the first valid index g wins.
  - Results in cycle k+1:
    - byte_ready=1
    - req_ready[g]=1
    - tx_data=req_data[g] (captured at edge k)
    - grant_id=g
    - busy=1
    - state=SEND
    - pointer=g
- Requester protocol:
  - req_data must be stable while req_valid is high.
  - req_valid may drop without ever seeing req_ready (request withdrawn); a requester that drops req_valid before edge k is not granted.
- Timing, with byte_ready in cycle t and C=CLKS_PER_BIT:
  - bit_tick pulses in cycles t+nC, for n=1..10+GAP_BITS.
  - No bit_tick in cycle t, and no bit_tick in IDLE.
  - SEND→GAP at the 10th tick. GAP→IDLE at the final tick. With GAP_BITS=0, SEND→IDLE at the 10th tick.
- Final-tick arbitration:
  - Arbitration is also evaluated in the cycle of the final tick.
  - If a request is pending, the next byte_ready occurs at t+(10+GAP_BITS)C+1 and busy stays high.
  - Otherwise busy drops in that cycle.
- Back-to-back byte_ready period: (10+GAP_BITS)*C + 1 cycles.
- busy is high from cycle t through cycle t+(10+GAP_BITS)C inclusive.
- tx_data and grant_id hold their values until the next grant.
- Only one req_ready bit is ever high, and only coincident with byte_ready.
- Simultaneous requests: served strictly round-robin. A continuously-valid requester waits at most NUM_REQ-1 frames.
- Reset mid-frame: the frame aborts, outputs return to reset values, and any partially-shifted byte is lost. Reset never produces a req_ready or byte_ready pulse.
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit counter counts to 10+GAP_BITS.
  - No wrap-around artefacts; the counters are cleared on every grant.

Test Plan:
- Single request (C=16, G=1): req_valid[2]=1, data 8'hA5 at edge k.
  - byte_ready, req_ready=4'b0100, tx_data=A5, grant_id=2 in cycle k+1.
  - 11 bit_ticks, 16 cycles apart.
  - busy low after cycle k+1+176.
  - With the shifter attached, line carries 0,1,0,1,0,0,1,0,1,1 then idle-high.
- All four requesters valid continuously:
  - Grants in order 0,1,2,3,0.
  - byte_ready pulses exactly 177 cycles apart.
  - busy never drops.
- Request arriving mid-frame on another port:
  - Not granted until the final-tick cycle.
  - req_ready of the in-flight requester is not repeated.
- GAP_BITS=0, C=4, back-to-back requests on port 1:
  - byte_ready period 41 cycles, 10 ticks per frame.
  - State never dwells in GAP.
- Withdraw: req_valid[3] pulses high between ticks and drops before the final tick → never granted, no req_ready[3].
- Async reset asserted at tick 5 of a frame:
  - All outputs 0 immediately, no further ticks.
  - After release, a pending req_valid[1] is granted (pointer reset → priority order 0,1,…).
